// File: rtl/uart_pkg.sv
// Shared definitions for the board UART link (receive and transmit halves).
package uart_pkg;

    // Payload bits per frame.
    localparam int DATA_BITS = 8;

    // Receiver FSM states. PARITY is only reached in the UART_RX_PARITY_EN build.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Even parity check: returns 1 when the data bits plus the parity bit hold an odd count of ones.
    function automatic logic even_parity_err(input logic [DATA_BITS-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
    parameter int unsigned WIDTH       = 1,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Capture the async input, then re-register to let metastability settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{RESET_VALUE}};
            sync_q <= {WIDTH{RESET_VALUE}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples rx with the system clock and samples each bit at its centre.
// Default build receives 8N1 frames. Defining UART_RX_PARITY_EN adds an even-parity bit
// between the data and stop bits and enables parity_err_o; the port list is unchanged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 framing_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int unsigned HALF  = CLOCKS_PER_BAUD / 2;
    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BAUD);

    // Start bit is checked half a bit in; every later bit one full period after the previous.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_flag_q, par_flag_d;
    logic                 perr_q, perr_d;
`endif

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state logic: bit timing, deserialisation and end-of-frame status.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flag_d = par_flag_q;
        perr_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // Line back high at mid-start: a glitch, not a frame.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d      = '0;
                    par_flag_d = even_parity_err(shift_q, rx_s);
                    state_d    = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = '0;
                    // Leave at mid-stop so the next start edge is caught even with baud skew.
                    state_d = IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_flag_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity result of the current frame and its registered error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_flag_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            par_flag_q <= par_flag_d;
            perr_q     <= perr_d;
        end
    end

    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign framing_err_o = ferr_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Follows UART_RX_PARITY_EN to match the DUT build.
module tb_uart_rx;

    localparam int CPB  = 33;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
    localparam bit PAR_ON   = 1'b1;
`else
    localparam int STOP_IDX = 9;
    localparam bit PAR_ON   = 1'b0;
`endif
    // Drive edge to the status-pulse cycle: 2 sync flops, t0 decision, stop sample, register.
    localparam int LAT = 3 + HALF + STOP_IDX * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       framing_err_o;
    logic       parity_err_o;
    logic       busy_o;

    uart_rx #(
        .CLOCKS_PER_BAUD (CPB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .framing_err_o (framing_err_o),
        .parity_err_o  (parity_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  kind;      // {parity_err, framing_err, valid}
        logic [7:0]  data;
        logic        busy_now;
        logic        busy_prev;
    } ev_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    ev_t  mon_ev;
    logic prev_busy = 1'b0;

    // Record every cycle carrying a status pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && (valid_o || framing_err_o || parity_err_o)) begin
            mon_ev.cyc       = cyc;
            mon_ev.kind      = {parity_err_o, framing_err_o, valid_o};
            mon_ev.data      = data_o;
            mon_ev.busy_now  = busy_o;
            mon_ev.busy_prev = prev_busy;
            obs_q.push_back(mon_ev);
        end
        prev_busy <= busy_o;
    end

    int         n_assert  = 0;
    int         n_fail    = 0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame and queue the pulse the receiver should produce for it.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int gap);
        ev_t e;
        e.cyc       = cyc + LAT;
        e.busy_now  = 1'b0;
        e.busy_prev = 1'b1;
        if (!stop) begin
            e.kind = 3'b010;
            e.data = last_data;
        end else if (PAR_ON && (((^b) ^ par) != 1'b0)) begin
            e.kind = 3'b100;
            e.data = last_data;
        end else begin
            e.kind    = 3'b001;
            e.data    = b;
            last_data = b;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
        if (gap > 0) idle(gap);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk($sformatf("%s.count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s[%0d].kind", tag, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            chk($sformatf("%s[%0d].data", tag, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(obs_q[i].busy_now), 32'(exp_q[i].busy_now));
            chk($sformatf("%s[%0d].busy_prev", tag, i), 32'(obs_q[i].busy_prev),
                32'(exp_q[i].busy_prev));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s.data", tag), 32'(data_o), 32'h0);
        chk($sformatf("%s.valid", tag), 32'(valid_o), 32'h0);
        chk($sformatf("%s.ferr", tag), 32'(framing_err_o), 32'h0);
        chk($sformatf("%s.perr", tag), 32'(parity_err_o), 32'h0);
        chk($sformatf("%s.busy", tag), 32'(busy_o), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        logic       p;
        logic       s;
        int         g;

        // Reset state.
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(10);

        // Single good frame.
        send_frame(8'hA5, 1'b0, 1'b1, 5);
        check_events("a5");
        chk("a5.data_hold", 32'(data_o), 32'hA5);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 5);
        check_events("b2b");

        // 100 ns glitch on an idle line.
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rx = 1'b1;
        chk("glitch.busy_high", 32'(busy_o), 32'h1);
        repeat (10) @(posedge clk);
        #1;
        chk("glitch.busy_low", 32'(busy_o), 32'h0);
        idle(40);
        check_events("glitch");

        // Stop bit low: framing error, data held.
        send_frame(8'h3C, 1'b0, 1'b0, 2 * CPB);
        check_events("ferr");
        chk("ferr.data_hold", 32'(data_o), 32'(last_data));

`ifdef UART_RX_PARITY_EN
        send_frame(8'hA5, 1'b1, 1'b1, 5);
        check_events("perr");
        send_frame(8'hA5, 1'b0, 1'b1, 5);
        check_events("par_ok");
`endif

        // Reset in the middle of data bit 4 of 0x81.
        b = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_data = 8'h00;
        idle(2 * CPB);
        send_frame(8'h5A, 1'b0, 1'b1, 5);
        check_events("after_rst");

        // Random frames, some with bad stop or parity bits.
        for (int k = 0; k < 48; k++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            p = (^b) ^ ($urandom_range(0, 4) == 0);
            g = s ? int'($urandom_range(0, 3)) : CPB;
            send_frame(b, p, s, g);
        end
        idle(CPB);
        check_events("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
